// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus arbiter: controller state encoding and bus frame geometry.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } bus_state_e;

    localparam int ADDR_BITS  = 12;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester after last_owner, wrapping at N.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_owner,
    output logic            found,
    output logic [ID_W-1:0] pick
);

    int cand_s;

    // Scan offsets 1..N from last_owner so the previous owner is considered last.
    always_comb begin
        found  = 1'b0;
        pick   = {ID_W{1'b0}};
        cand_s = 0;
        for (int off = 1; off <= N; off++) begin
            cand_s = (int'(last_owner) + off) % N;
            pick   = (!found && req[cand_s[ID_W-1:0]]) ? cand_s[ID_W-1:0] : pick;
            found  = found | req[cand_s[ID_W-1:0]];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the serial system bus, with one dead cycle between owners
// and a watchdog that reclaims the bus from an owner that never finishes its frame.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 1,
    parameter int TIMEOUT     = 64,
    parameter int TO_W        = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic                   tx_done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_W-1:0]        owner,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    localparam logic [TO_W-1:0]        WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]        WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]        WD_MAX  = {TO_W{1'b1}};
    localparam logic                   WD_EN   = (TIMEOUT != 0);
    localparam logic [NUM_MASTERS-1:0] GRANT_0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]        LAST_ID = ID_W'(NUM_MASTERS - 1);

    bus_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        last_owner_q, last_owner_d;
    logic                   busy_q, busy_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]        wd_cnt_q, wd_cnt_d;

    logic                   found_s;
    logic [ID_W-1:0]        pick_s;
    logic                   wd_expire_s;

    rr_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req        (m_req),
        .last_owner (last_owner_q),
        .found      (found_s),
        .pick       (pick_s)
    );

    assign wd_expire_s = WD_EN && (wd_cnt_q == WD_LAST);

    // Next-state and output decode for the IDLE/BUSY/TURN controller.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = {NUM_MASTERS{1'b0}};
                busy_d  = 1'b0;
                if (found_s) begin
                    state_d      = ST_BUSY;
                    grant_d      = GRANT_0 << pick_s;
                    owner_d      = pick_s;
                    last_owner_d = pick_s;
                    busy_d       = 1'b1;
                    wd_cnt_d     = {TO_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : (wd_cnt_q + WD_ONE);
                // Completion outranks the watchdog, so a frame finishing on the last allowed cycle is not an error.
                if (tx_done || !m_req[owner_q]) begin
                    state_d = ST_TURN;
                    grant_d = {NUM_MASTERS{1'b0}};
                    busy_d  = 1'b0;
                end else if (wd_expire_s) begin
                    state_d       = ST_TURN;
                    grant_d       = {NUM_MASTERS{1'b0}};
                    busy_d        = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                grant_d = {NUM_MASTERS{1'b0}};
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_MASTERS{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, grant, owner, watchdog and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= {NUM_MASTERS{1'b0}};
            owner_q       <= {ID_W{1'b0}};
            last_owner_q  <= LAST_ID;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= {TO_W{1'b0}};
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign owner       = owner_q;
    assign bus_busy    = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a driver applies directed then random stimulus and queues the
// expected outputs from an ownership-level reference model; a monitor pops and compares every cycle.
module tb_bus_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 64;

    logic         clk;
    logic         reset;
    logic [1:0]   m_req;
    logic         tx_done;
    logic [1:0]   grant;
    logic [0:0]   owner;
    logic         bus_busy;
    logic         timeout_err;

    typedef struct {
        logic [1:0] grant;
        logic       owner;
        logic       busy;
        logic       terr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   started     = 1'b0;
    bit   done_drive  = 1'b0;

    // reference model: phase 0 = bus free, 1 = owned, 2 = dead cycle after release
    int   ph, mo, ml, age;
    bit   te;

    bus_arbiter #(
        .NUM_MASTERS (2),
        .ID_W        (1),
        .TIMEOUT     (TIMEOUT),
        .TO_W        (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_req       (m_req),
        .tx_done     (tx_done),
        .grant       (grant),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, advance the model, queue what the next rise must show.
    task automatic cyc(input logic r, input logic [1:0] rq, input logic d);
        exp_t e;
        bit   claimed;
        @(negedge clk);
        reset   = r;
        m_req   = rq;
        tx_done = d;
        te      = 1'b0;
        if (!r) begin
            ph = 0; mo = 0; ml = N - 1; age = 0;
        end else if (ph == 0) begin
            claimed = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ml + k) % N;
                if (!claimed && rq[c]) begin
                    claimed = 1'b1;
                    ph = 1; mo = c; ml = c; age = 0;
                end
            end
        end else if (ph == 1) begin
            age = age + 1;
            if (d || !rq[mo]) begin
                ph = 2;
            end else if (TIMEOUT != 0 && age == TIMEOUT) begin
                ph = 2;
                te = 1'b1;
            end
        end else begin
            ph = 0;
        end
        e.grant = (ph == 1) ? (2'b01 << mo) : 2'b00;
        e.owner = mo[0];
        e.busy  = (ph == 1);
        e.terr  = te;
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic hold(input int n, input logic [1:0] rq);
        for (int i = 0; i < n; i++) cyc(1'b1, rq, 1'b0);
    endtask

    // Monitor: compare DUT outputs with the queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (exp_q.size() == 0) begin
                    if (!done_drive) chk("queue_underflow", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", int'(grant), int'(e.grant));
                    chk("bus_busy", int'(bus_busy), int'(e.busy));
                    chk("owner", int'(owner), int'(e.owner));
                    chk("timeout_err", int'(timeout_err), int'(e.terr));
                    chk("busy_vs_grant", int'(bus_busy), int'(|grant));
                    chk("grant_onehot0", int'($countones(grant) <= 1), 1);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        logic [1:0] rq;
        reset = 1'b0; m_req = 2'b00; tx_done = 1'b0;
        ph = 0; mo = 0; ml = N - 1; age = 0; te = 1'b0;

        // reset, then both request: master 0 wins first
        cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b1, 2'b11, 1'b0);
        hold(3, 2'b11);
        // frame done while master 1 waits: dead cycle then master 1
        cyc(1'b1, 2'b11, 1'b1);
        hold(4, 2'b11);
        cyc(1'b1, 2'b11, 1'b1);
        // tx_done during TURN/IDLE is ignored
        cyc(1'b1, 2'b00, 1'b1);
        cyc(1'b1, 2'b00, 1'b1);

        // master 0 alone drops its request after 5 busy cycles
        cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b1, 2'b01, 1'b0);
        hold(5, 2'b01);
        hold(3, 2'b00);

        // watchdog: request held, no tx_done, then re-grant to master 0
        cyc(1'b1, 2'b01, 1'b0);
        hold(70, 2'b01);
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);

        // tx_done on the last allowed busy cycle: no timeout_err
        cyc(1'b1, 2'b10, 1'b0);
        hold(63, 2'b10);
        cyc(1'b1, 2'b10, 1'b1);
        hold(2, 2'b00);

        // reset mid-frame, then master 1 alone
        cyc(1'b1, 2'b01, 1'b0);
        hold(4, 2'b01);
        cyc(1'b0, 2'b01, 1'b0);
        cyc(1'b1, 2'b10, 1'b0);
        hold(3, 2'b10);

        // randomized traffic with slowly changing requests
        rq = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
            end
            cyc(($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0, rq,
                ($urandom_range(0, 23) == 0) ? 1'b1 : 1'b0);
        end

        @(posedge clk);
        #2;
        done_drive = 1'b1;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
